// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point constants for the PageRank iteration engine.
package pagerank_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_WAIT,
        S_SWAP,
        S_DONE
    } sched_state_t;

    // Uniform starting rank 2^width / n (n is a power of two).
    function automatic longint rank_init(input int width, input int n);
        return (64'd1 << width) / n;
    endfunction

    // Default geometry N=16, WIDTH=16.
    localparam logic [15:0] RANK_INIT = 16'(rank_init(16, 16));

    // Damping constants shared with the update datapath (fraction of 2^16).
    localparam logic [15:0] PR_D           = 16'h2666;
    localparam logic [15:0] PR_ONE_MINUS_D = 16'hD99A;
    localparam logic [15:0] PR_D_OVER_N    = 16'h0266;

endpackage

// File: rtl/pagerank_rank_buf.sv
// Double-buffered rank register file: cur = bank[sel], nxt = bank[~sel].
module pagerank_rank_buf #(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [WIDTH-1:0] init_val,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_val,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_val,
    input  logic [IDX_W-1:0] dl_idx,
    output logic [WIDTH-1:0] dl_val
);

    logic [1:0][N-1:0][WIDTH-1:0] bank;
    logic                         sel;

    // Bank-wide init of cur, single-entry writes into nxt.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (init)
                    bank[sel][i] <= init_val;
                if (wr_en && wr_idx == IDX_W'(i))
                    bank[~sel][i] <= wr_val;
            end
        end
    end

    // Buffer select flips at each iteration boundary.
    always_ff @(posedge clk) begin
        if (reset)
            sel <= 1'b0;
        else if (swap)
            sel <= ~sel;
    end

    assign rd_val = bank[sel][rd_idx];
    assign dl_val = bank[sel][dl_idx];

endmodule

// File: rtl/pagerank_iter_sched.sv
// Iteration scheduler: issues one node update at a time, commits results
// into the next-iteration buffer and stops on tolerance or iteration limit.
import pagerank_pkg::*;

module pagerank_iter_sched #(
    parameter int N      = 16,
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [WIDTH-1:0]  tol,
    output logic              req_valid,
    output logic [IDX_W-1:0]  req_node,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [WIDTH-1:0]  rsp_val,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WIDTH-1:0]  rd_val,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(rank_init(WIDTH, N));

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  node_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] max_iter_q;
    logic [WIDTH-1:0]  tol_q;
    logic [WIDTH:0]    maxd_q;
    logic              conv_q;

    logic              buf_init, buf_wr, buf_swap;
    logic [WIDTH-1:0]  cur_val;
    logic [WIDTH:0]    cur_ext, rsp_ext, delta;
    logic [ITER_W-1:0] eff_max;
    logic              last_node, conv_hit, iter_hit;

    pagerank_rank_buf #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .init     (buf_init),
        .init_val (INIT_VAL),
        .wr_en    (buf_wr),
        .wr_idx   (node_q),
        .wr_val   (rsp_val),
        .swap     (buf_swap),
        .rd_idx   (rd_idx),
        .rd_val   (rd_val),
        .dl_idx   (node_q),
        .dl_val   (cur_val)
    );

    // Unsigned |new - old| one bit wider so it never wraps.
    assign cur_ext   = {1'b0, cur_val};
    assign rsp_ext   = {1'b0, rsp_val};
    assign delta     = (rsp_ext >= cur_ext) ? rsp_ext - cur_ext : cur_ext - rsp_ext;

    assign eff_max   = (max_iter_q == '0) ? ITER_W'(1) : max_iter_q;
    assign last_node = (node_q == IDX_W'(N - 1));
    assign conv_hit  = (maxd_q <= {1'b0, tol_q});
    assign iter_hit  = ((iter_q + ITER_W'(1)) == eff_max);

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and buffer control strobes.
    always_comb begin
        state_d  = state_q;
        buf_init = 1'b0;
        buf_wr   = 1'b0;
        buf_swap = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT: begin
                buf_init = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: if (req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (rsp_valid) begin
                    buf_wr  = 1'b1;
                    state_d = last_node ? S_SWAP : S_ISSUE;
                end
            end
            S_SWAP: begin
                buf_swap = 1'b1;
                state_d  = (conv_hit || iter_hit) ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Run parameters, node/iteration counters and max-delta tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            node_q     <= '0;
            iter_q     <= '0;
            max_iter_q <= '0;
            tol_q      <= '0;
            maxd_q     <= '0;
            conv_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        max_iter_q <= max_iter;
                        tol_q      <= tol;
                    end
                end
                S_INIT: begin
                    node_q <= '0;
                    iter_q <= '0;
                    maxd_q <= '0;
                    conv_q <= 1'b0;
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (delta > maxd_q)
                            maxd_q <= delta;
                        if (!last_node)
                            node_q <= node_q + IDX_W'(1);
                    end
                end
                S_SWAP: begin
                    iter_q <= iter_q + ITER_W'(1);
                    if (conv_hit) begin
                        conv_q <= 1'b1;
                    end else if (!iter_hit) begin
                        maxd_q <= '0;
                        node_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_valid  = (state_q == S_ISSUE);
    assign req_node   = node_q;
    assign busy       = (state_q == S_INIT) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT) || (state_q == S_SWAP);
    assign done       = (state_q == S_DONE);
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_pagerank_iter_sched.sv
// Self-checking bench for pagerank_iter_sched: directed table plus random runs
// against an iteration-level rank model.
module tb_pagerank_iter_sched;

    localparam int N      = 16;
    localparam int WIDTH  = 16;
    localparam int ITER_W = 8;
    localparam int IDX_W  = 4;
    localparam int RINIT  = 4096;

    logic              clk = 1'b0;
    logic              reset, start, req_ready, rsp_valid;
    logic [ITER_W-1:0] max_iter;
    logic [WIDTH-1:0]  tol, rsp_val, rd_val;
    logic [IDX_W-1:0]  rd_idx, req_node;
    logic              req_valid, busy, done, converged;
    logic [ITER_W-1:0] iter_count;

    always #20 clk = ~clk;

    pagerank_iter_sched #(.N(N), .WIDTH(WIDTH), .ITER_W(ITER_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .max_iter   (max_iter),
        .tol        (tol),
        .req_valid  (req_valid),
        .req_node   (req_node),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_val    (rsp_val),
        .rd_idx     (rd_idx),
        .rd_val     (rd_val),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Activity monitor: busy cycles, run entries (first busy cycle) and done pulses.
    int   busy_cnt = 0, entry_cnt = 0, done_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && !prev_busy) entry_cnt++;
        if (done) done_cnt++;
        prev_busy = busy;
    end

    // Reference rank vectors and run outcome.
    int mcur[N];
    int mnxt[N];
    int m_conv, m_iter;
    bit aborted;

    task automatic chk(input string nm, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rd(input string nm, input bit zero);
        for (int i = 0; i < N; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            chk(nm, rd_val, zero ? 0 : mcur[i]);
        end
    endtask

    // Responder: 0 = fixed point, 1 = cur + 0x10, 2 = random walk around cur.
    function automatic int resp(input int mode, input int cur);
        int v;
        case (mode)
            0: v = RINIT;
            1: v = (cur + 16) & 16'hFFFF;
            default: begin
                if ($urandom_range(0, 15) == 0)
                    v = int'($urandom_range(0, 65535));
                else
                    v = cur + int'($urandom_range(0, 96)) - 48;
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
            end
        endcase
        return v;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (req_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("req_timeout", 0, 1);
    endtask

    task automatic mid_reset();
        reset = 1'b1; rsp_valid = 1'b1; rsp_val = 16'h1234;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_req_valid", req_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_conv", converged, 0);
        chk("mrst_iter", iter_count, 0);
        chk("mrst_node", req_node, 0);
        chk_rd("mrst_rd", 1'b1);
        // late response lands in IDLE and must be dropped
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("late_rsp_busy", busy, 0);
        chk_rd("late_rsp_rd", 1'b1);
    endtask

    task automatic run(input int mi, input int tl, input int mode, input int stall,
                       input bit spur, input bit rst_mid);
        int eff, mmax, d, v, b0, e0, d0;
        bit ok, fin;
        for (int i = 0; i < N; i++) mcur[i] = RINIT;
        eff = (mi == 0) ? 1 : mi;
        m_iter = 0; m_conv = 0; fin = 1'b0;
        @(negedge clk);
        b0 = busy_cnt; e0 = entry_cnt; d0 = done_cnt;
        start = 1'b1; max_iter = ITER_W'(mi); tol = WIDTH'(tl);
        @(negedge clk);
        start = 1'b0;
        chk("init_busy", busy, 1);
        chk("init_req_valid", req_valid, 0);
        if (spur) begin start = 1'b1; max_iter = '0; tol = '1; end
        while (!fin) begin
            mmax = 0;
            for (int n = 0; n < N; n++) begin
                wait_req(ok);
                start = 1'b0;
                if (!ok) begin aborted = 1'b1; return; end
                chk("req_node", req_node, n);
                for (int s = 0; s < stall; s++) begin
                    if (spur && s == 0) begin rsp_valid = 1'b1; rsp_val = 16'hBEEF; end
                    @(negedge clk);
                    rsp_valid = 1'b0;
                    chk("hold_valid", req_valid, 1);
                    chk("hold_node", req_node, n);
                end
                req_ready = 1'b1;
                @(negedge clk);
                req_ready = 1'b0;
                chk("valid_drop", req_valid, 0);
                if (rst_mid && m_iter == 1 && n == 5) begin
                    mid_reset();
                    return;
                end
                v = resp(mode, mcur[n]);
                rsp_valid = 1'b1; rsp_val = WIDTH'(v);
                @(negedge clk);
                rsp_valid = 1'b0;
                mnxt[n] = v;
                d = (v > mcur[n]) ? v - mcur[n] : mcur[n] - v;
                if (d > mmax) mmax = d;
            end
            mcur = mnxt;
            m_iter++;
            if (mmax <= tl) begin m_conv = 1; fin = 1'b1; end
            else if (m_iter == eff) fin = 1'b1;
        end
        // SWAP cycle, then DONE, then IDLE
        chk("swap_busy", busy, 1);
        chk("swap_done", done, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("converged", converged, m_conv);
        chk("iter_count", iter_count, m_iter);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("done_once", done_cnt - d0, 1);
        chk("busy_from_first_req", (busy_cnt - b0) - (entry_cnt - e0),
            m_iter * (N * (stall + 2) + 1));
        chk_rd("final_rd", 1'b0);
    endtask

    typedef struct {
        int mi;
        int tl;
        int mode;
        int stall;
        bit spur;
        int exp_conv;
        int exp_iter;
        int exp_rd0;
    } vec_t;

    vec_t tbl[5];

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; max_iter = '0; tol = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_val = '0; rd_idx = '0;
        aborted = 1'b0;

        tbl[0] = '{mi: 3, tl: 0, mode: 0, stall: 0, spur: 0, exp_conv: 1, exp_iter: 1, exp_rd0: 'h1000};
        tbl[1] = '{mi: 4, tl: 8, mode: 1, stall: 0, spur: 0, exp_conv: 0, exp_iter: 4, exp_rd0: 'h1040};
        tbl[2] = '{mi: 3, tl: 0, mode: 0, stall: 5, spur: 0, exp_conv: 1, exp_iter: 1, exp_rd0: 'h1000};
        tbl[3] = '{mi: 4, tl: 8, mode: 1, stall: 1, spur: 1, exp_conv: 0, exp_iter: 4, exp_rd0: 'h1040};
        tbl[4] = '{mi: 0, tl: 0, mode: 1, stall: 0, spur: 0, exp_conv: 0, exp_iter: 1, exp_rd0: 'h1010};

        repeat (2) @(negedge clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", converged, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_node", req_node, 0);
        chk_rd("rst_rd", 1'b1);
        reset = 1'b0;

        for (int t = 0; t < 5; t++) begin
            run(tbl[t].mi, tbl[t].tl, tbl[t].mode, tbl[t].stall, tbl[t].spur, 1'b0);
            if (aborted) begin
                do_reset();
                aborted = 1'b0;
            end else begin
                chk("tbl_conv", converged, tbl[t].exp_conv);
                chk("tbl_iter", iter_count, tbl[t].exp_iter);
                rd_idx = '0;
                #1;
                chk("tbl_rd0", rd_val, tbl[t].exp_rd0);
            end
        end

        // reset in WAIT of the second iteration, then a normal run
        run(4, 8, 1, 0, 1'b0, 1'b1);
        if (aborted) begin do_reset(); aborted = 1'b0; end
        run(4, 8, 1, 0, 1'b0, 1'b0);
        if (aborted) begin do_reset(); aborted = 1'b0; end
        else chk("post_rst_iter", iter_count, 4);

        for (int r = 0; r < 10; r++) begin
            run(int'($urandom_range(0, 5)), int'($urandom_range(0, 48)), 2,
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
            if (aborted) begin do_reset(); aborted = 1'b0; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pagerank_iter_sched.md
# pagerank_iter_sched

Iteration scheduler and rank buffer for the PageRank node-update datapath. It holds the rank vector in a double-buffered register file and issues one node-update request at a time to the update datapath. The datapath reads previous-iteration ranks through a read port, and the scheduler commits each returned value into the next-iteration buffer. At each iteration boundary it swaps buffers and stops on convergence (max |delta| ≤ tol) or on the iteration limit.

## Interface
Parameters:
- N, 16, number of nodes (power of two, ≥ 2)
- WIDTH, 16, rank width, unsigned fraction (value/2^WIDTH)
- ITER_W, 8, iteration counter width
- IDX_W, $clog2(N), node index width

Ports:
- clk  in  1  clock; everything on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- max_iter  in  ITER_W  iteration limit, latched at start; 0 treated as 1
- tol  in  WIDTH  convergence threshold, latched at start
- req_valid  out  1  node-update request valid
- req_node  out  IDX_W  node to update
- req_ready  in  1  datapath accepts request
- rsp_valid  in  1  result valid (1-cycle strobe)
- rsp_val  in  WIDTH  new rank for req_node
- rd_idx  in  IDX_W  datapath/host read index
- rd_val  out  WIDTH  cur-buffer rank at rd_idx, combinational
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at end of run
- converged  out  1  last run ended on tolerance; held until next start
- iter_count  out  ITER_W  completed iterations; held until next start

## Operation
- Storage: two N×WIDTH banks and a sel bit. cur = bank[sel], nxt = bank[~sel]. rd_val always reads cur.
- States: IDLE, INIT, ISSUE, WAIT, SWAP, DONE.
- IDLE: when start=1, latch max_iter and tol, then go to INIT. start is ignored in all other states.
- INIT (1 cycle):
  - every cur entry = 2^WIDTH/N (0x1000 for N=16, WIDTH=16)
  - node=0, iter_count=0, maxdelta=0, converged=0
  - go to ISSUE
- ISSUE: req_valid=1, req_node=node. On req_ready=1, go to WAIT.
- WAIT:
  - On rsp_valid: nxt[node]=rsp_val; delta=|rsp_val−cur[node]| computed unsigned at WIDTH+1 bits, no wrap; maxdelta=max(maxdelta, delta).
  - If node==N−1, go to SWAP. Otherwise node++ and go to ISSUE.
  - rsp_valid in any other state is ignored.
- SWAP (1 cycle): sel toggles, iter_count++.
  - If maxdelta ≤ tol: converged=1, go to DONE.
  - Else if iter_count+1 == effective max_iter: go to DONE with converged=0.
  - Else maxdelta=0, node=0, go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. cur now holds the final ranks.
- busy=1 in INIT, ISSUE, WAIT and SWAP.
- Reset (any state, including mid-run):
  - state=IDLE, sel=0, both banks cleared to 0
  - req_valid=0, busy=0, done=0, converged=0, iter_count=0, req_node=0
  - an outstanding request is abandoned; a late rsp_valid is ignored

## Timing
- start high at edge k: INIT during cycle k+1, req_valid first high in cycle k+2.
- req_valid and req_node come from registered state and are stable until the handshake. req_valid drops the cycle after req_ready.
- Minimum per node is 2 cycles (ready at once, response the next cycle). Minimum per iteration is 2N+1 cycles (33 for N=16).
- done rises the cycle after SWAP. busy falls in the same cycle done rises.
- A new start is accepted the cycle after done.
- rd_val is combinational from rd_idx; the datapath registers it if needed.
- A cur write (INIT) or sel toggle (SWAP) is visible on rd_val the following cycle.

## Structure
- Package pagerank_pkg holds:
  - state enum
  - localparam RANK_INIT = 2^WIDTH/N
  - the shared fixed-point constants d = 0x2666, 1−d, and d/N, reused by the datapath
- Sub-module pagerank_rank_buf provides:
  - two banks and sel
  - a bank-wide init port and the nxt write port
  - cur read ports: one combinational for rd_idx, one internal for delta
  - a swap strobe
- The FSM, counters and maxdelta compare live in the top.

## Test plan
- Reset, then start with max_iter=3, tol=0. A responder returns 0x1000 for every node (fixed point). Required: converged=1, iter_count=1, done exactly once, 33 busy cycles, rd_val=0x1000 for all idx.
- Responder returns cur[node]+0x10 each iteration; max_iter=4, tol=0x8. Required: converged=0, iter_count=4, rd_val(0)=0x1040.
- req_ready withheld for 5 cycles per request. Required: req_valid/req_node stable throughout, one request per node, in order 0..N−1.
- Spurious rsp_valid in ISSUE, plus a start pulse while busy. Required: no bank write, no restart, result identical to the clean run.
- Reset asserted in WAIT of iteration 2. Required: next cycle state IDLE, all outputs 0, rd_val=0 for all idx. A following start runs normally.
- max_iter=0 with a non-converging responder. Required: exactly 1 iteration, iter_count=1, converged=0.
